// File: rtl/seg_mux_driver_pkg.sv
// Shared types and the hex font for the multiplexed seven-segment driver.
// Glyphs are active-high; output polarity is applied only at the output registers.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h00;

  // seg[0]=A ... seg[6]=G
  function automatic seg_t hex_to_seg(input logic [3:0] hex);
    seg_t s;
    case (hex)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_mux_driver_if.sv
// Digit/mask inputs and segment/anode outputs of the display driver.
// The master side supplies digits and masks; the slave side is the driver.
interface seg_mux_driver_if #(
  parameter int NUM_DIGITS = 2
);
  import seg_pkg::*;

  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   blink_mask;
  seg_t                    seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_strobe;

  modport master (
    output digits, blank_mask, blink_mask,
    input  seg, an, frame_strobe
  );

  modport slave (
    input  digits, blank_mask, blink_mask,
    output seg, an, frame_strobe
  );

endinterface

// File: rtl/seg_mux_driver_tick_gen.sv
// Free-running modulo-DIV counter; tick is high on the last count, i.e. the
// cycle whose rising edge wraps the counter back to zero.
module tick_gen #(
  parameter int DIV     = 2,
  parameter int W       = (DIV > 1) ? $clog2(DIV) : 1,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         reset,
  output logic [W-1:0] cnt,
  output logic         tick
);

  localparam logic [W-1:0] LAST  = W'(DIV - 1);
  localparam logic [W-1:0] START = W'(RST_VAL);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= START;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seg_mux_driver.sv
// Time-multiplexed hex display driver: one slot per digit, each slot starts
// with all anodes dark so the segment bus can change without ghosting.
module seg_mux_driver
  import seg_pkg::*;
#(
  parameter int CLK_HZ         = 12_000_000,
  parameter int NUM_DIGITS     = 2,
  parameter int REFRESH_HZ     = 500,
  parameter int BLANK_CYCLES   = 24,
  parameter int BLINK_HZ       = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  seg_mux_driver_if.slave bus
);

  localparam int SLOT_CYCLES = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int BLINK_HALF  = (BLINK_HZ > 0) ? CLK_HZ / (2 * BLINK_HZ) : 1;
  localparam int CNT_W       = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]      SHOW_AT  = CNT_W'(BLANK_CYCLES - 1);
  localparam seg_t                  SEG_IDLE = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [NUM_DIGITS-1:0] AN_IDLE  = AN_ACTIVE_LOW ? '1 : '0;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seg_mux_driver: NUM_DIGITS must be in 1..8");
  end
  if (SLOT_CYCLES < BLANK_CYCLES + 2) begin : g_bad_slot
    $error("seg_mux_driver: slot too short for the blanking interval");
  end

  logic [CNT_W-1:0] cnt;
  logic             slot_wrap;
  logic             blink_tick;

  tick_gen #(
    .DIV     (SLOT_CYCLES),
    .W       (CNT_W),
    .RST_VAL (SLOT_CYCLES - 1)
  ) u_slot (
    .clk   (clk),
    .reset (reset),
    .cnt   (cnt),
    .tick  (slot_wrap)
  );

  if (BLINK_HZ > 0) begin : g_blink
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    logic [BW-1:0] blink_cnt_unused;
    tick_gen #(
      .DIV     (BLINK_HALF),
      .W       (BW),
      .RST_VAL (0)
    ) u_blink (
      .clk   (clk),
      .reset (reset),
      .cnt   (blink_cnt_unused),
      .tick  (blink_tick)
    );
  end else begin : g_no_blink
    assign blink_tick = 1'b0;
  end

  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  blank_s_q, blank_s_d;
  logic                  blink_off_q, blink_off_d;
  seg_t                  seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  strobe_q, strobe_d;

  logic                  show_entry;
  logic                  lit;
  logic [NUM_DIGITS-1:0] onehot;

  always_comb begin
    idx_d       = idx_q;
    blank_s_d   = blank_s_q;
    seg_d       = seg_q;
    an_d        = an_q;
    strobe_d    = 1'b0;
    blink_off_d = blink_off_q ^ blink_tick;
    lit         = 1'b0;
    onehot      = '0;

    // With no blanking interval the SHOW decision lands on the slot-entry edge.
    show_entry = slot_wrap ? (BLANK_CYCLES == 0) : (cnt == SHOW_AT);

    if (slot_wrap) begin
      idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      seg_d     = SEG_ACTIVE_LOW ? ~hex_to_seg(bus.digits[{idx_d, 2'b00} +: 4])
                                 :  hex_to_seg(bus.digits[{idx_d, 2'b00} +: 4]);
      an_d      = AN_IDLE;
      blank_s_d = bus.blank_mask[idx_d];
      strobe_d  = (idx_d == '0);
    end

    if (show_entry) begin
      lit         = !blank_s_d && !(bus.blink_mask[idx_d] && blink_off_q);
      onehot[idx_d] = lit;
      an_d        = AN_ACTIVE_LOW ? ~onehot : onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q       <= IDX_LAST;
      blank_s_q   <= 1'b0;
      blink_off_q <= 1'b0;
      seg_q       <= SEG_IDLE;
      an_q        <= AN_IDLE;
      strobe_q    <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      blank_s_q   <= blank_s_d;
      blink_off_q <= blink_off_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      strobe_q    <= strobe_d;
    end
  end

  assign bus.seg          = seg_q;
  assign bus.an           = an_q;
  assign bus.frame_strobe = strobe_q;

endmodule
